parking_gate_arbiter: RTL

//  Shares one parking-spot pool between NUM_GATES entry gates. Round-robin arbitrates entry

---
 rtl/parking_gate_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: round-robin entry arbitration over a shared spot pool, with lowest-free allocation and barrier-open sequencing.
// Optional feature macro PARK_RESERVE_EN: the top spot is held back for gate 0.
module parking_gate_arbiter #(
  parameter int NUM_GATES      = 2,
  parameter int NUM_SPOTS      = 8,
  parameter int BARRIER_CYCLES = 4,
  localparam int SPOT_W        = $clog2(NUM_SPOTS),
  localparam int CNT_W         = $clog2(NUM_SPOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] enter_req,
  input  logic                 exit_valid,
  input  logic [SPOT_W-1:0]    exit_spot,
  output logic [NUM_GATES-1:0] enter_gnt,
  output logic [SPOT_W-1:0]    gnt_spot,
  output logic                 barrier_open,
  output logic [CNT_W-1:0]     available_slots,
  output logic                 parking_full,
  output logic                 exit_err
);
  localparam int GATE_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int TMR_W  = $clog2(BARRIER_CYCLES + 1);

  // state | meaning
  // IDLE  | waiting for an eligible request with a spot available
  // GRANT | one-cycle grant pulse; spot is marked at the end of it
  // OPEN  | barrier held open for BARRIER_CYCLES cycles
  typedef enum logic [1:0] {IDLE, GRANT, OPEN} state_t;

  state_t               state;
  logic [NUM_SPOTS-1:0] occ, occ_next, occ_clr, occ_set;
  logic [NUM_SPOTS-1:0] gen_mask, free_all, free_gen, pool;
  logic [NUM_GATES-1:0] elig;
  logic [GATE_W-1:0]    rr_ptr, grant_gate, win;
  logic [SPOT_W-1:0]    spot;
  logic [TMR_W-1:0]     tmr;
  logic [CNT_W-1:0]     used_next;
  logic                 exit_bad, full_next;

  always_comb begin
    gen_mask = '1;
`ifdef PARK_RESERVE_EN
    gen_mask[NUM_SPOTS-1] = 1'b0;
`endif
    free_all = ~occ;
    free_gen = free_all & gen_mask;
    // A gate only competes when a spot it may take exists, so a blocked gate never stalls gate 0.
    for (int i = 0; i < NUM_GATES; i++)
      elig[i] = enter_req[i] && ((i == 0) ? (free_all != '0) : (free_gen != '0));
    win = '0;
    for (int k = NUM_GATES - 1; k >= 0; k--)
      if (elig[(int'(rr_ptr) + k) % NUM_GATES]) win = GATE_W'((int'(rr_ptr) + k) % NUM_GATES);
    pool = (win == '0) ? free_all : free_gen;
    spot = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--)
      if (pool[i]) spot = SPOT_W'(i);

    exit_bad = 1'b0;
    occ_clr  = '0;
    if (exit_valid) begin
      exit_bad = 1'b1;
      for (int i = 0; i < NUM_SPOTS; i++)
        if (exit_spot == SPOT_W'(i) && occ[i]) begin
          exit_bad   = 1'b0;
          occ_clr[i] = 1'b1;
        end
    end
    occ_set = '0;
    if (state == GRANT)
      for (int i = 0; i < NUM_SPOTS; i++)
        if (gnt_spot == SPOT_W'(i)) occ_set[i] = 1'b1;
    occ_next  = (occ & ~occ_clr) | occ_set;
    used_next = '0;
    for (int i = 0; i < NUM_SPOTS; i++)
      used_next = used_next + CNT_W'(occ_next[i]);
    full_next = &(occ_next | ~gen_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      occ             <= '0;
      rr_ptr          <= '0;
      grant_gate      <= '0;
      tmr             <= '0;
      enter_gnt       <= '0;
      gnt_spot        <= '0;
      barrier_open    <= 1'b0;
      exit_err        <= 1'b0;
      parking_full    <= 1'b0;
      available_slots <= CNT_W'(NUM_SPOTS);
    end else begin
      occ             <= occ_next;
      available_slots <= CNT_W'(NUM_SPOTS) - used_next;
      parking_full    <= full_next;
      exit_err        <= exit_bad;
      case (state)
        IDLE: begin
          if (elig != '0) begin
            state      <= GRANT;
            grant_gate <= win;
            gnt_spot   <= spot;
            enter_gnt  <= NUM_GATES'(1) << win;
          end
        end
        GRANT: begin
          state        <= OPEN;
          enter_gnt    <= '0;
          barrier_open <= 1'b1;
          tmr          <= TMR_W'(BARRIER_CYCLES - 1);
          rr_ptr       <= (int'(grant_gate) == NUM_GATES - 1) ? '0 : grant_gate + 1'b1;
        end
        OPEN: begin
          if (tmr == '0) begin
            state        <= IDLE;
            barrier_open <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
